led_pattern_gen: RTL and testbench

//  Parametrised LED pattern engine, next generation of the fixed 8-LED water light.

---
 rtl/led_pattern_gen.sv | 134 +++++++++++++
 tb/tb_led_pattern_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED bar pattern engine: divides clk into a step tick, drives an N-bit bar in one of four modes
// and rotates packed 3-bit RGB channels. Optional PWM dimming when LED_PWM_EN is defined.
module led_pattern_gen #(
  parameter int                 LED_W    = 8,
  parameter int                 RGB_N    = 4,
  parameter int                 TICK_DIV = 600,
  parameter logic [3*RGB_N-1:0] LD_INIT  = 12'b101_101_110_011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
`ifdef LED_PWM_EN
  input  logic [7:0]         duty,
`endif
  output logic [LED_W-1:0]   led,
  output logic [3*RGB_N-1:0] ld,
  output logic               tick
);

  localparam int                CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [LED_W-1:0]  LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};

  logic [CW-1:0]      r_cnt;
  logic               r_tick;
  logic [LED_W-1:0]   r_led;
  logic [3*RGB_N-1:0] r_ld;
  logic               r_dir_up;
  logic [1:0]         r_mode_q;

  logic               w_mode_chg;
  logic               w_cnt_last;
  logic [LED_W-1:0]   w_led_nxt;
  logic               w_dir_nxt;
  logic [3*RGB_N-1:0] w_ld_nxt;

  assign w_mode_chg = (mode != r_mode_q);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir_up;
    case (r_mode_q)
      2'b00: w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
      2'b01: w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
      2'b10: begin
        // turn around at the ends so neither end LED is lit twice in a row
        if (r_dir_up && r_led[LED_W-1]) begin
          w_dir_nxt = 1'b0;
          w_led_nxt = r_led >> 1;
        end else if (!r_dir_up && r_led[0]) begin
          w_dir_nxt = 1'b1;
          w_led_nxt = r_led << 1;
        end else if (r_dir_up) begin
          w_led_nxt = r_led << 1;
        end else begin
          w_led_nxt = r_led >> 1;
        end
      end
      default: begin
        if (&r_led) w_led_nxt = '0;
        else        w_led_nxt = {r_led[LED_W-2:0], 1'b1};
      end
    endcase
  end

  always_comb begin
    w_ld_nxt = r_ld;
    for (int k = 0; k < RGB_N; k++) begin
      w_ld_nxt[3*k +: 3] = {r_ld[3*k], r_ld[3*k+1 +: 2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_led    <= LED_ONE;
      r_ld     <= LD_INIT;
      r_dir_up <= 1'b1;
      r_mode_q <= mode;
    end else if (w_mode_chg) begin
      // mode change restarts the bar and divider but leaves the RGB phase alone
      r_mode_q <= mode;
      r_cnt    <= '0;
      r_led    <= LED_ONE;
      r_dir_up <= 1'b1;
      r_tick   <= 1'b0;
    end else if (en) begin
      r_tick <= w_cnt_last;
      if (w_cnt_last) begin
        r_cnt    <= '0;
        r_led    <= w_led_nxt;
        r_ld     <= w_ld_nxt;
        r_dir_up <= w_dir_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

`ifdef LED_PWM_EN
  logic [7:0]         r_pwm_cnt;
  logic               r_pwm_on;
  logic [LED_W-1:0]   r_led_pin;
  logic [3*RGB_N-1:0] r_ld_pin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_pwm_on  <= 1'b0;
      r_led_pin <= '0;
      r_ld_pin  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm_on  <= (r_pwm_cnt < duty);
      r_led_pin <= r_led & {LED_W{r_pwm_on}};
      r_ld_pin  <= r_ld & {(3*RGB_N){r_pwm_on}};
    end
  end

  assign led = r_led_pin;
  assign ld  = r_ld_pin;
`else
  assign led = r_led;
  assign ld  = r_ld;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: an 8-LED instance for rotate/ping-pong/freeze/mode-change/reset
// and a 4-LED instance for fill/clear with a single RGB channel.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, en, rst2, en2;
  logic [1:0]  mode, mode2;
  logic [7:0]  led;
  logic [11:0] ld;
  logic        tick;
  logic [3:0]  led_b;
  logic [2:0]  ld_b;
  logic        tick_b;
`ifdef LED_PWM_EN
  logic [7:0]  duty, duty2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.LED_W(8), .RGB_N(4), .TICK_DIV(4), .LD_INIT(12'b101_101_110_011)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .led(led), .ld(ld), .tick(tick)
  );

  led_pattern_gen #(.LED_W(4), .RGB_N(1), .TICK_DIV(4), .LD_INIT(3'b101)) dut_b (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2),
`ifdef LED_PWM_EN
    .duty(duty2),
`endif
    .led(led_b), .ld(ld_b), .tick(tick_b)
  );

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int pp_idx [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  logic [3:0] fill_exp [5] = '{4'h3, 4'h7, 4'hF, 4'h0, 4'h1};
  logic [2:0] ldb_exp  [5] = '{3'b110, 3'b011, 3'b101, 3'b110, 3'b011};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 2'b11;
`ifdef LED_PWM_EN
    duty = 8'd255; duty2 = 8'd255;
`endif
    clk_n(2);
    chk("rst_led", led, 32'h01);
    chk("rst_ld", ld, 32'hB73);
    chk("rst_tick", tick, 0);

    // rotate right, tick every 4 clocks
    rst = 1'b0; en = 1'b1;
    clk_n(3); chk("t1_early", tick, 0);
    clk_n(1); chk("t1_tick", tick, 1); chk("t1_led", led, 32'h80); chk("t1_ld", ld, 32'hD9D);
    clk_n(1); chk("tick_pulse", tick, 0);
    clk_n(3); chk("t2_tick", tick, 1); chk("t2_led", led, 32'h40);
    clk_n(4); chk("t3_tick", tick, 1); chk("t3_led", led, 32'h20); chk("t3_ld", ld, 32'hB73);

    // freeze mid-count at cnt=2
    clk_n(2); en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      chk("frz_led", led, 32'h20);
      chk("frz_tick", tick, 0);
    end
    chk("frz_ld", ld, 32'hB73);
    en = 1'b1;
    clk_n(1); chk("resume_early", tick, 0);
    clk_n(1); chk("resume_tick", tick, 1); chk("resume_led", led, 32'h10); chk("resume_ld", ld, 32'hD9D);

    // mode change on the terminal count cycle beats the step
    clk_n(3); mode = 2'b01;
    clk_n(1); chk("mc_led", led, 32'h01); chk("mc_tick", tick, 0); chk("mc_ld", ld, 32'hD9D);
    clk_n(3); chk("mc_early", tick, 0);
    clk_n(1); chk("mc_tick2", tick, 1); chk("rotl_led", led, 32'h02); chk("mc_ld2", ld, 32'h6EE);

    // ping-pong over 15 steps
    mode = 2'b10;
    clk_n(1); chk("pp_start", led, 32'h01);
    for (int i = 0; i < 15; i++) begin
      clk_n(4);
      chk("pp_tick", tick, 1);
      chk("pp_led", led, 32'h1 << pp_idx[i]);
    end

    // synchronous reset mid-run
    clk_n(2); rst = 1'b1;
    clk_n(1); chk("rst2_led", led, 32'h01); chk("rst2_ld", ld, 32'hB73); chk("rst2_tick", tick, 0);
    rst = 1'b0;
    clk_n(3); chk("rst2_early", tick, 0);
    clk_n(1); chk("rst2_tick1", tick, 1); chk("rst2_pp", led, 32'h02);

    // fill/clear on the 4-LED instance
    chk("b_rst_led", led_b, 32'h1); chk("b_rst_ld", ld_b, 32'h5);
    rst2 = 1'b0; en2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_n(4);
      chk("b_tick", tick_b, 1);
      chk("b_fill", led_b, fill_exp[i]);
      chk("b_ld", ld_b, ldb_exp[i]);
    end

`ifdef LED_PWM_EN
    begin
      int hi;
      hi = 0;
      en = 1'b0; duty = 8'd64;
      clk_n(4);
      for (int i = 0; i < 256; i++) begin
        clk_n(1);
        if (led[1]) hi++;
      end
      chk("pwm_64", hi, 64);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
